// File: rtl/img_row_streamer.sv
// rtl/img_row_streamer.sv - streams a grayscale frame row-wise from image memory to the line buffer
module img_row_streamer #(
    parameter int IMG_COLS = 540,
    parameter int IMG_ROWS = 960,
    parameter int ADDR_W   = 20,
    parameter int COL_W    = 10,
    parameter int ROW_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              row_ack_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    output logic [7:0]        data_o,
    output logic              data_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ROW_W-1:0]  cnt_row_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_WAIT_ACK,
        S_ROW,
        S_FLUSH
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMG_COLS - 1);
    localparam logic [ROW_W-1:0] FRAME_ROWS = ROW_W'(IMG_ROWS);
    localparam logic [ROW_W-1:0] PRIME_ROWS = ROW_W'(3);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              ack_pend;
    logic              rd_v;

    logic [ROW_W-1:0]  row_next;
    logic              ack_any;

    // Row count after the row currently being issued completes, and any release request seen
    always_comb begin
        row_next = row + ROW_W'(1);
        ack_any  = ack_pend | row_ack_i;
    end

    // Frame sequencer, read issue, 2-stage read pipeline and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            addr        <= '0;
            col         <= '0;
            row         <= '0;
            ack_pend    <= 1'b0;
            rd_v        <= 1'b0;
            mem_rd_en_o <= 1'b0;
            mem_addr_o  <= '0;
            data_o      <= '0;
            data_en_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            cnt_row_o   <= '0;
        end else begin
            done_o      <= 1'b0;
            mem_rd_en_o <= 1'b0;
            rd_v        <= mem_rd_en_o;
            data_en_o   <= rd_v;
            if (rd_v) begin
                data_o <= mem_rdata_i;
            end

            if (state != S_IDLE && abort_i) begin
                // Drop everything in flight so no pre-abort pixel reaches the line buffer
                state     <= S_IDLE;
                busy_o    <= 1'b0;
                rd_v      <= 1'b0;
                data_en_o <= 1'b0;
                ack_pend  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i && !abort_i) begin
                            addr      <= base_addr_i;
                            col       <= '0;
                            row       <= '0;
                            cnt_row_o <= '0;
                            ack_pend  <= 1'b0;
                            busy_o    <= 1'b1;
                            state     <= S_PRIME;
                        end
                    end

                    S_PRIME, S_ROW: begin
                        mem_rd_en_o <= 1'b1;
                        mem_addr_o  <= addr;
                        addr        <= addr + ADDR_W'(1);
                        if (row_ack_i) begin
                            ack_pend <= 1'b1;
                        end
                        if (col == LAST_COL) begin
                            col       <= '0;
                            row       <= row_next;
                            cnt_row_o <= row_next;
                            if (row_next == FRAME_ROWS) begin
                                ack_pend <= 1'b0;
                                state    <= S_FLUSH;
                            end else if (state == S_ROW || row_next == PRIME_ROWS) begin
                                // A release already seen lets the next row follow without a gap
                                ack_pend <= 1'b0;
                                state    <= ack_any ? S_ROW : S_WAIT_ACK;
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end

                    S_WAIT_ACK: begin
                        if (ack_any) begin
                            ack_pend <= 1'b0;
                            state    <= S_ROW;
                        end
                    end

                    S_FLUSH: begin
                        if (!mem_rd_en_o && !rd_v) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_img_row_streamer.sv
// tb/tb_img_row_streamer.sv - randomized self-checking bench for img_row_streamer
module tb_img_row_streamer;

    localparam int COLS   = 4;
    localparam int ROWS   = 5;
    localparam int ADDR_W = 20;
    localparam int COL_W  = 10;
    localparam int ROW_W  = 10;
    localparam int BEATS  = COLS * ROWS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic              row_ack_i = 1'b0;
    logic              mem_rd_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_rdata_i = '0;
    logic [7:0]        data_o;
    logic              data_en_o;
    logic              busy_o;
    logic              done_o;
    logic [ROW_W-1:0]  cnt_row_o;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] beat_q[$];
    int         beat_cyc[$];
    int         rd_cyc[$];
    int         done_cnt  = 0;
    int         done_cyc  = 0;
    int         done_busy = 0;

    img_row_streamer #(
        .IMG_COLS(COLS), .IMG_ROWS(ROWS), .ADDR_W(ADDR_W), .COL_W(COL_W), .ROW_W(ROW_W)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .base_addr_i(base_addr_i), .row_ack_i(row_ack_i),
        .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
        .data_o(data_o), .data_en_o(data_en_o), .busy_o(busy_o), .done_o(done_o),
        .cnt_row_o(cnt_row_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_rd_en_o) mem_rdata_i <= mem_addr_o[7:0];
    end

    always @(negedge clk) begin
        if (data_en_o) begin
            beat_q.push_back(data_o);
            beat_cyc.push_back(cyc);
        end
        if (mem_rd_en_o) rd_cyc.push_back(cyc);
        if (done_o) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = int'(busy_o);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        tests = tests + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        beat_q.delete();
        beat_cyc.delete();
        rd_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        base_addr_i = base;
        start_i     = 1'b1;
        run(1);
        start_i     = 1'b0;
    endtask

    task automatic pulse_ack();
        row_ack_i = 1'b1;
        run(1);
        row_ack_i = 1'b0;
    endtask

    // Keeps releasing rows every gap cycles until the frame reports done or the budget runs out
    task automatic frame_run(input int gap, input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            row_ack_i = ((k % gap) == gap - 1);
            run(1);
            k++;
        end
        row_ack_i = 1'b0;
        run(3);
    endtask

    // Reference: the n-th beat of a frame is the low byte of base + n
    task automatic check_stream(input string tag, input int base, input int n);
        int bad;
        bad = 0;
        check({tag, "_count"}, beat_q.size(), n);
        for (int i = 0; i < beat_q.size() && i < n; i++)
            if (beat_q[i] != 8'((base + i) & 8'hFF)) bad++;
        check({tag, "_values"}, bad, 0);
    endtask

    function automatic int gaps(input int from, input int to);
        int g;
        g = 0;
        for (int i = from + 1; i <= to && i < beat_cyc.size(); i++)
            if (beat_cyc[i] != beat_cyc[i-1] + 1) g++;
        return g;
    endfunction

    initial begin
        int base;
        int nb;
        int n;

        run(3);
        check("reset_outputs",
              {mem_rd_en_o, mem_addr_o, data_o, data_en_o, busy_o, done_o, cnt_row_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(2);

        // Prime three rows with no acks
        clear_logs();
        do_start(20'h10);
        check("busy_after_start", busy_o, 1);
        run(30);
        check_stream("prime", 'h10, 3 * COLS);
        check("prime_gaps", gaps(0, 3 * COLS - 1), 0);
        check("first_latency", (beat_cyc.size() > 0 && rd_cyc.size() > 0) ? beat_cyc[0] - rd_cyc[0] : -1, 2);
        check("prime_busy", busy_o, 1);
        check("prime_no_done", done_cnt, 0);
        check("prime_cnt_row", cnt_row_o, 3);
        pulse_ack();
        run(20);
        check_stream("row4", 'h10, 4 * COLS);
        pulse_ack();
        run(20);
        check_stream("frame1", 'h10, BEATS);
        check("frame1_done", done_cnt, 1);
        check("done_after_last", done_cyc - beat_cyc[beat_cyc.size()-1], 1);
        check("done_busy", done_busy, 0);
        check("idle_busy", busy_o, 0);

        // Early acks during PRIME: first is held, second dropped
        clear_logs();
        base = $urandom_range(0, 20'hFFF00);
        do_start(ADDR_W'(base));
        run(2);
        pulse_ack();
        run(2);
        pulse_ack();
        run(40);
        check_stream("early", base, 4 * COLS);
        check("early_gaps", gaps(0, 4 * COLS - 1), 0);
        check("early_no_done", done_cnt, 0);
        frame_run(9, 200);
        check_stream("early_full", base, BEATS);
        check("early_done", done_cnt, 1);

        // Abort on the 6th PRIME read
        clear_logs();
        do_start(20'h40);
        n = 0;
        for (int k = 0; k < 50 && n < 6; k++) begin
            @(negedge clk);
            if (mem_rd_en_o) n++;
        end
        check("abort_reached", n, 6);
        abort_i = 1'b1;
        run(1);
        abort_i = 1'b0;
        nb = beat_q.size();
        check("abort_busy", busy_o, 0);
        check("abort_rd_en", mem_rd_en_o, 0);
        check("abort_beats_before", nb, 4);
        run(20);
        check("abort_no_more_beats", beat_q.size(), nb);
        check("abort_no_done", done_cnt, 0);
        clear_logs();
        do_start(20'h80);
        frame_run(8, 200);
        check_stream("post_abort", 'h80, BEATS);
        check("post_abort_done", done_cnt, 1);

        // Reset asserted in the middle of a ROW
        clear_logs();
        do_start(20'h200);
        run(16);
        pulse_ack();
        run(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrow_reset_outputs",
              {mem_rd_en_o, mem_addr_o, data_o, data_en_o, busy_o, done_o, cnt_row_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(2);
        clear_logs();
        base = $urandom_range(0, 20'hFFF00);
        do_start(ADDR_W'(base));
        frame_run(7, 200);
        check_stream("post_reset", base, BEATS);
        check("post_reset_done", done_cnt, 1);

        // start+abort together in IDLE, then a stray start mid-frame
        clear_logs();
        base_addr_i = 20'h300;
        start_i = 1'b1;
        abort_i = 1'b1;
        run(1);
        start_i = 1'b0;
        abort_i = 1'b0;
        run(10);
        check("start_abort_busy", busy_o, 0);
        check("start_abort_reads", rd_cyc.size(), 0);
        do_start(20'h500);
        run(6);
        do_start(20'h600);
        frame_run(10, 200);
        check_stream("stray_start", 'h500, BEATS);
        check("stray_start_done", done_cnt, 1);

        // Randomized frames with random release spacing
        for (int f = 0; f < 3; f++) begin
            clear_logs();
            base = $urandom_range(0, 20'hFFF00);
            do_start(ADDR_W'(base));
            frame_run($urandom_range(1, 15), 400);
            check_stream("rand_frame", base, BEATS);
            check("rand_done", done_cnt, 1);
            run($urandom_range(1, 5));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
